// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 exception controller shared definitions.
// Register numbers, exception codes, field positions, FSM states.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_BD  = 31;
    localparam int CA_TI  = 30;

    localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_FLUSH_EXC  = 2'd1,
        S_FLUSH_ERET = 2'd2
    } cp0_state_e;

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// CP0 Count/Compare timer: half-rate Count, sticky TI.
// TI latches on Count==Compare and clears only on a Compare write.
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    // Timer register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    // Next-state: software writes override the increment / match.
    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q + {31'd0, tick_q};
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (count_we_i) begin
            count_d = wdata_i;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage.
// Commits CP0 state and sequences a one-cycle flush + redirect.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_valid_M,
    input  logic        stall_M,
    input  logic [31:0] pc_M,
    input  logic [31:0] sl_addr_M,
    input  logic        in_ds_M,
    input  logic        exc,
    input  logic [4:0]  exc_code,
    input  logic        eret_M,
    input  logic        mtc0_M,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [5:0]  hw_int,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc
);

    cp0_state_e  state_q, state_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [1:0]  ipsw_q, ipsw_d;
    logic [5:0]  iphw_q;

    logic [31:0] count_w, compare_w;
    logic        ti_w;
    logic [7:0]  ip_w;
    logic [31:0] cause_w;
    logic        int_req, commit_ok, take, eret_c, mtc0_c;
    logic [4:0]  code_sel;

    assign ip_w    = {iphw_q[5] | ti_w, iphw_q[4:0], ipsw_q};
    assign cause_w = {bd_q, ti_w, 14'd0, ip_w, 1'b0, code_q, 2'b00};

    // Interrupt and commit qualification use pre-write state.
    assign int_req   = status_q[ST_IE] & ~status_q[ST_EXL]
                     & (|(ip_w & status_q[15:8]));
    assign commit_ok = inst_valid_M & ~stall_M & (state_q == S_RUN);
    assign take      = commit_ok & (int_req | exc);
    assign eret_c    = commit_ok & eret_M & ~take;
    assign mtc0_c    = commit_ok & mtc0_M & ~take;
    assign code_sel  = int_req ? EXC_INT : exc_code;

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (mtc0_c & (cp0_addr == CP0_COUNT)),
        .compare_we_i (mtc0_c & (cp0_addr == CP0_COMPARE)),
        .wdata_i      (cp0_wdata),
        .count_o      (count_w),
        .compare_o    (compare_w),
        .ti_o         (ti_w)
    );

    // Architectural CP0 registers and FSM state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_RUN;
            status_q <= STATUS_RST;
            epc_q    <= '0;
            badv_q   <= '0;
            bd_q     <= 1'b0;
            code_q   <= '0;
            ipsw_q   <= '0;
            iphw_q   <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            epc_q    <= epc_d;
            badv_q   <= badv_d;
            bd_q     <= bd_d;
            code_q   <= code_d;
            ipsw_q   <= ipsw_d;
            iphw_q   <= hw_int;
        end
    end

    // Register updates: exception entry beats ERET and MTC0.
    always_comb begin
        status_d = status_q;
        epc_d    = epc_q;
        badv_d   = badv_q;
        bd_d     = bd_q;
        code_d   = code_q;
        ipsw_d   = ipsw_q;
        if (take) begin
            if (!status_q[ST_EXL]) begin
                epc_d = in_ds_M ? (pc_M - 32'd4) : pc_M;
                bd_d  = in_ds_M;
            end
            status_d[ST_EXL] = 1'b1;
            code_d           = code_sel;
            if (code_sel == EXC_ADEL || code_sel == EXC_ADES) begin
                badv_d = (pc_M[1:0] != 2'b00) ? pc_M : sl_addr_M;
            end
        end else begin
            if (mtc0_c) begin
                case (cp0_addr)
                    CP0_STATUS: status_d = (cp0_wdata & STATUS_WMASK)
                                         | (STATUS_RST & ~STATUS_WMASK);
                    CP0_CAUSE:  ipsw_d = cp0_wdata[9:8];
                    CP0_EPC:    epc_d = cp0_wdata;
                    default:    ;
                endcase
            end
            if (eret_c) begin
                status_d[ST_EXL] = 1'b0;
            end
        end
    end

    // Flush FSM: one flush/redirect cycle, then back to RUN.
    always_comb begin
        state_d        = S_RUN;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            S_RUN: begin
                if (take) begin
                    state_d = S_FLUSH_EXC;
                end else if (eret_c) begin
                    state_d = S_FLUSH_ERET;
                end
            end
            S_FLUSH_EXC: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
            end
            S_FLUSH_ERET: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = epc_q;
            end
            default: ;
        endcase
    end

    // MFC0 read port.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_BADVADDR: cp0_rdata = badv_q;
            CP0_COUNT:    cp0_rdata = count_w;
            CP0_COMPARE:  cp0_rdata = compare_w;
            CP0_STATUS:   cp0_rdata = status_q;
            CP0_CAUSE:    cp0_rdata = cause_w;
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign status = status_q;
    assign cause  = cause_w;
    assign epc    = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl.
// Directed scenarios plus a randomized run against a behavioural model.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam logic [31:0] SRST = 32'h0040_0000;
    localparam logic [31:0] WM   = 32'h0000_FF03;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_valid_M, stall_M, in_ds_M, exc, eret_M, mtc0_M;
    logic [31:0] pc_M, sl_addr_M, cp0_wdata;
    logic [4:0]  exc_code, cp0_addr;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata, redirect_pc, status, cause, epc;
    logic        flush, redirect_valid;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
    logic        m_tick, m_ti, m_bd;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    int          m_fk; // 0 none, 1 exception redirect, 2 eret redirect

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .resetn(resetn), .inst_valid_M(inst_valid_M),
        .stall_M(stall_M), .pc_M(pc_M), .sl_addr_M(sl_addr_M),
        .in_ds_M(in_ds_M), .exc(exc), .exc_code(exc_code),
        .eret_M(eret_M), .mtc0_M(mtc0_M), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .hw_int(hw_int), .cp0_rdata(cp0_rdata),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .status(status), .cause(cause),
        .epc(epc)
    );

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'd0, m_iphw[5] | m_ti, m_iphw[4:0],
                m_ipsw, 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause();
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_rpc();
        if (m_fk == 1) return VEC;
        if (m_fk == 2) return m_epc;
        return 32'd0;
    endfunction

    // Apply the architectural rules for one clock edge using current inputs.
    task automatic model_update();
        logic [7:0]  ip;
        logic        ir, go, tk, er, wr, nti;
        logic [4:0]  code;
        logic [31:0] ncount;
        if (!resetn) begin
            m_status = SRST; m_epc = 0; m_badv = 0; m_count = 0;
            m_compare = 0; m_tick = 0; m_ti = 0; m_bd = 0;
            m_code = 0; m_ipsw = 0; m_iphw = 0; m_fk = 0;
            return;
        end
        ip = {m_iphw[5] | m_ti, m_iphw[4:0], m_ipsw};
        ir = m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 0);
        go = (m_fk == 0) && inst_valid_M && !stall_M;
        tk = go && (ir || exc);
        er = go && eret_M && !tk;
        wr = go && mtc0_M && !tk;
        ncount = (wr && cp0_addr == 5'd9) ? cp0_wdata
               : m_count + (m_tick ? 32'd1 : 32'd0);
        nti = (wr && cp0_addr == 5'd11) ? 1'b0
            : (m_ti || (m_count == m_compare));
        if (wr && cp0_addr == 5'd11) m_compare = cp0_wdata;
        m_count = ncount;
        m_ti    = nti;
        m_tick  = !m_tick;
        m_iphw  = hw_int;
        if (tk) begin
            code = ir ? 5'd0 : exc_code;
            if (!m_status[1]) begin
                m_epc = in_ds_M ? pc_M - 32'd4 : pc_M;
                m_bd  = in_ds_M;
            end
            m_status[1] = 1'b1;
            m_code = code;
            if (code == 5'd4 || code == 5'd5)
                m_badv = (pc_M[1:0] != 0) ? pc_M : sl_addr_M;
        end else begin
            if (wr) begin
                case (cp0_addr)
                    5'd12: m_status = (cp0_wdata & WM) | (SRST & ~WM);
                    5'd13: m_ipsw = cp0_wdata[9:8];
                    5'd14: m_epc = cp0_wdata;
                    default: ;
                endcase
            end
            if (er) m_status[1] = 1'b0;
        end
        m_fk = tk ? 1 : (er ? 2 : 0);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_valid_M = 0; stall_M = 0; in_ds_M = 0; exc = 0;
        eret_M = 0; mtc0_M = 0; pc_M = 0; sl_addr_M = 0;
        exc_code = 0; cp0_addr = 0; cp0_wdata = 0;
    endtask

    task automatic do_reset();
        idle();
        hw_int = 0;
        resetn = 0;
        step();
        resetn = 1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        inst_valid_M = 1; mtc0_M = 1; cp0_addr = a; cp0_wdata = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        cp0_addr = 5'd9;
        #1;
        checks++; if (status !== SRST) begin errors++;
            $display("FAIL reset_status got %h want %h", status, SRST); end
        checks++; if (cause !== 32'd0) begin errors++;
            $display("FAIL reset_cause got %h want 0", cause); end
        checks++; if (epc !== 32'd0) begin errors++;
            $display("FAIL reset_epc got %h want 0", epc); end
        checks++; if ({flush, redirect_valid, redirect_pc} !== 34'd0) begin
            errors++;
            $display("FAIL reset_redirect got %b %b %h want 0 0 0",
                     flush, redirect_valid, redirect_pc); end
        checks++; if (cp0_rdata !== 32'd0) begin errors++;
            $display("FAIL reset_count got %h want 0", cp0_rdata); end
    endtask

    task automatic test_sys_in_slot();
        do_reset();
        inst_valid_M = 1; pc_M = 32'h8000_0010; exc = 1;
        exc_code = 5'h08; in_ds_M = 1;
        step();
        idle();
        checks++; if (epc !== 32'h8000_000C) begin errors++;
            $display("FAIL sys_epc got %h want 8000000c", epc); end
        checks++; if ({cause[31], cause[6:2], status[1]} !== {1'b1, 5'h08, 1'b1})
        begin errors++;
            $display("FAIL sys_fields got bd=%b code=%h exl=%b want 1 08 1",
                     cause[31], cause[6:2], status[1]); end
        checks++; if ({flush, redirect_valid, redirect_pc} !== {2'b11, VEC}) begin
            errors++;
            $display("FAIL sys_redirect got %b %b %h want 1 1 %h",
                     flush, redirect_valid, redirect_pc, VEC); end
        step();
        checks++; if ({flush, redirect_valid} !== 2'b00) begin errors++;
            $display("FAIL sys_flush_drop got %b%b want 00",
                     flush, redirect_valid); end
    endtask

    task automatic test_adel();
        do_reset();
        inst_valid_M = 1; pc_M = 32'h8000_0020; sl_addr_M = 32'h1000_0002;
        exc = 1; exc_code = 5'h04;
        step();
        idle(); cp0_addr = 5'd8; #1;
        checks++; if (cp0_rdata !== 32'h1000_0002) begin errors++;
            $display("FAIL adel_badv got %h want 10000002", cp0_rdata); end
        do_reset();
        inst_valid_M = 1; pc_M = 32'h8000_0022; sl_addr_M = 32'h1000_0002;
        exc = 1; exc_code = 5'h04;
        step();
        idle(); cp0_addr = 5'd8; #1;
        checks++; if (cp0_rdata !== 32'h8000_0022) begin errors++;
            $display("FAIL adel_pc_badv got %h want 80000022", cp0_rdata); end
    endtask

    task automatic test_nested();
        do_reset();
        inst_valid_M = 1; pc_M = 32'h8000_0300; exc = 1; exc_code = 5'h08;
        step();
        idle(); step();
        inst_valid_M = 1; pc_M = 32'h8000_0400; exc = 1; exc_code = 5'h0c;
        in_ds_M = 1;
        step();
        idle();
        checks++; if (epc !== 32'h8000_0300 || cause[31] !== 1'b0) begin
            errors++;
            $display("FAIL nested_epc got %h bd=%b want 80000300 0",
                     epc, cause[31]); end
        checks++; if (cause[6:2] !== 5'h0c || redirect_pc !== VEC) begin
            errors++;
            $display("FAIL nested_code got %h pc %h want 0c %h",
                     cause[6:2], redirect_pc, VEC); end
    endtask

    task automatic test_eret();
        do_reset();
        mtc0(5'd14, 32'h8000_0100);
        mtc0(5'd12, 32'h0000_0002);
        checks++; if (status !== 32'h0040_0002) begin errors++;
            $display("FAIL eret_setup_status got %h want 00400002", status); end
        inst_valid_M = 1; eret_M = 1;
        step();
        idle();
        checks++; if (status[1] !== 1'b0) begin errors++;
            $display("FAIL eret_exl got %b want 0", status[1]); end
        checks++; if ({flush, redirect_valid, redirect_pc} !==
                      {2'b11, 32'h8000_0100}) begin errors++;
            $display("FAIL eret_redirect got %b %b %h want 1 1 80000100",
                     flush, redirect_valid, redirect_pc); end
        step();
        mtc0(5'd12, 32'h0000_0002);
        inst_valid_M = 1; eret_M = 1; exc = 1; exc_code = 5'h09;
        pc_M = 32'h8000_0200;
        step();
        idle();
        checks++; if (redirect_pc !== VEC || status[1] !== 1'b1) begin
            errors++;
            $display("FAIL eret_vs_exc got %h exl=%b want %h 1",
                     redirect_pc, status[1], VEC); end
        checks++; if (epc !== 32'h8000_0100 || cause[6:2] !== 5'h09) begin
            errors++;
            $display("FAIL eret_vs_exc_epc got %h code %h want 80000100 09",
                     epc, cause[6:2]); end
    endtask

    task automatic test_interrupt();
        do_reset();
        hw_int = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        step();
        inst_valid_M = 1; stall_M = 1; pc_M = 32'h8000_0040;
        mtc0_M = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (flush !== 1'b0 || status[1] !== 1'b0) begin
                errors++;
                $display("FAIL int_stall got flush=%b exl=%b want 0 0",
                         flush, status[1]); end
        end
        stall_M = 0;
        step();
        idle();
        checks++; if (flush !== 1'b1 || cause[6:2] !== 5'h00) begin
            errors++;
            $display("FAIL int_take got flush=%b code=%h want 1 00",
                     flush, cause[6:2]); end
        checks++; if (status !== 32'h0040_0403 || epc !== 32'h8000_0040) begin
            errors++;
            $display("FAIL int_state got %h epc %h want 00400403 80000040",
                     status, epc); end
        checks++; if (cause[10] !== 1'b1) begin errors++;
            $display("FAIL int_ip2 got %b want 1", cause[10]); end
        hw_int = 0;
    endtask

    task automatic test_timer();
        bit seen;
        do_reset();
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        checks++; if (cause[30] !== 1'b0) begin errors++;
            $display("FAIL timer_ti_clear got %b want 0", cause[30]); end
        seen = 0;
        for (int i = 0; i < 14 && !seen; i++) begin
            step();
            checks++; if (cause[30] !== m_ti) begin errors++;
                $display("FAIL timer_ti_track got %b want %b",
                         cause[30], m_ti); end
            seen = cause[30];
        end
        checks++; if (!seen) begin errors++;
            $display("FAIL timer_ti_timeout got 0 want 1"); end
        checks++; if (cause[15] !== 1'b1) begin errors++;
            $display("FAIL timer_ip7 got %b want 1", cause[15]); end
        mtc0(5'd11, 32'd1000);
        checks++; if (cause[30] !== 1'b0) begin errors++;
            $display("FAIL timer_cmp_clear got %b want 0", cause[30]); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        cp0_addr = 5'd9;
        for (int i = 0; i < 4 && cp0_rdata == 32'hFFFF_FFFF; i++) step();
        checks++; if (cp0_rdata !== 32'd0) begin errors++;
            $display("FAIL timer_wrap got %h want 0", cp0_rdata); end
    endtask

    task automatic test_reset_midflush();
        do_reset();
        inst_valid_M = 1; pc_M = 32'h8000_0500; exc = 1; exc_code = 5'h0a;
        step();
        idle();
        resetn = 0;
        step();
        resetn = 1;
        checks++; if ({flush, redirect_valid, redirect_pc} !== 34'd0) begin
            errors++;
            $display("FAIL midflush_reset got %b %b %h want 0 0 0",
                     flush, redirect_valid, redirect_pc); end
        step();
        checks++; if (flush !== 1'b0) begin errors++;
            $display("FAIL midflush_after got %b want 0", flush); end
    endtask

    task automatic test_random();
        logic [4:0] codes [6];
        logic [4:0] addrs [6];
        codes = '{5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        do_reset();
        for (int n = 0; n < 600; n++) begin
            resetn       = ($urandom_range(0, 99) != 0);
            inst_valid_M = ($urandom_range(0, 3) != 0);
            stall_M      = ($urandom_range(0, 3) == 0);
            in_ds_M      = $urandom_range(0, 1);
            exc          = ($urandom_range(0, 7) == 0);
            exc_code     = codes[$urandom_range(0, 5)];
            eret_M       = ($urandom_range(0, 7) == 0);
            mtc0_M       = ($urandom_range(0, 3) == 0);
            cp0_addr     = addrs[$urandom_range(0, 5)];
            cp0_wdata    = $urandom;
            pc_M         = $urandom;
            sl_addr_M    = $urandom;
            if ($urandom_range(0, 9) == 0) hw_int = 6'($urandom);
            step();
            checks++; if (status !== m_status || epc !== m_epc) begin
                errors++;
                $display("FAIL rnd_status_epc cyc %0d got %h %h want %h %h",
                         n, status, epc, m_status, m_epc); end
            checks++; if (cause !== m_cause()) begin errors++;
                $display("FAIL rnd_cause cyc %0d got %h want %h",
                         n, cause, m_cause()); end
            checks++; if (flush !== (m_fk != 0) ||
                          redirect_valid !== (m_fk != 0) ||
                          redirect_pc !== m_rpc()) begin errors++;
                $display("FAIL rnd_redirect cyc %0d got %b %b %h want fk=%0d %h",
                         n, flush, redirect_valid, redirect_pc, m_fk, m_rpc());
            end
            checks++; if (cp0_rdata !== m_read(cp0_addr)) begin errors++;
                $display("FAIL rnd_rdata cyc %0d addr %0d got %h want %h",
                         n, cp0_addr, cp0_rdata, m_read(cp0_addr)); end
        end
        resetn = 1;
    endtask

    initial begin
        idle();
        hw_int = 0;
        resetn = 0;
        test_reset();
        test_sys_in_slot();
        test_adel();
        test_nested();
        test_eret();
        test_interrupt();
        test_timer();
        test_reset_midflush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller at the M stage of the 5-stage MIPS pipeline.
- Consumes the per-instruction exception verdict (exc, exc_code) and merges it with hardware/timer interrupts.
- Commits Status/Cause/EPC/BadVAddr/Count/Compare state and handles ERET and MTC0/MFC0 accesses.
- Sequences a one-cycle pipeline flush plus PC redirect to the exception vector or EPC.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target on any exception/interrupt
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, EXL=0, IE=0, IM=0)

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- inst_valid_M  in  1  M-stage holds a real instruction (not a bubble)
- stall_M  in  1  M stage frozen this cycle; no commit
- pc_M  in  32  M-stage PC
- sl_addr_M  in  32  load/store effective address
- in_ds_M  in  1  M-stage instruction is in a branch delay slot
- exc  in  1  synchronous exception present
- exc_code  in  5  its code (04 AdEL, 05 AdES, 08 Sys, 09 Bp, 0a RI, 0c Ov)
- eret_M  in  1  ERET in M
- mtc0_M  in  1  MTC0 in M
- cp0_addr  in  5  CP0 register number (8,9,11,12,13,14)
- cp0_wdata  in  32  MTC0 data
- hw_int  in  6  external interrupt lines, level-sensitive
- cp0_rdata  out  32  combinational MFC0 read of cp0_addr
- flush  out  1  kill IF..M this cycle
- redirect_valid  out  1  fetch PC must be replaced
- redirect_pc  out  32  new fetch PC
- status, cause, epc  out  32 each  architectural values

Behaviour:
- Reset (resetn=0 at posedge): Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare, tick all 0; FSM=RUN; flush=0, redirect_valid=0, redirect_pc=0.
- Register fields:
  - Status: IM[15:8], EXL[1], IE[0] writable; other bits read back the reset value.
  - Cause: BD[31], TI[30], IP[15:10]=hw_int sampled each cycle, IP[9:8] software-writable, ExcCode[6:2].
- Timer:
  - tick toggles every cycle; Count increments when tick=1 (half clock rate).
  - Count==Compare sets TI; TI is sticky until Compare is written.
  - hw_int[5] is ORed with TI into IP[15].
- int_req = IE & ~EXL & |(Cause.IP & Status.IM).
- take = inst_valid_M & ~stall_M & (int_req | exc) & state==RUN. Interrupt has priority over exc; its ExcCode is 00.
- On take (posedge):
  - If EXL=0: EPC <= in_ds_M ? pc_M-4 : pc_M and BD <= in_ds_M. If EXL=1: EPC and BD are unchanged.
  - EXL <= 1; ExcCode <= selected code.
  - If code 04/05: BadVAddr <= (pc_M[1:0]!=0) ? pc_M : sl_addr_M.
- ERET: when inst_valid_M & ~stall_M & eret_M & ~take & state==RUN, EXL <= 0.
- MTC0: when inst_valid_M & ~stall_M & mtc0_M & ~take, write cp0_addr.
  - Writes to 8 (BadVAddr) and 13 except IP[9:8] are ignored.
  - A Count write overrides that cycle's increment.
  - A Compare write clears TI.
- FSM:
  - RUN -> FLUSH_EXC on take; RUN -> FLUSH_ERET on the ERET commit.
  - FLUSH_*: flush=1, redirect_valid=1 for exactly one cycle.
  - redirect_pc = EXC_VECTOR in FLUSH_EXC, EPC (post-update) in FLUSH_ERET.
  - Both FLUSH states return to RUN next cycle unconditionally, including when stall_M=1.
  - All M-stage inputs are ignored while in a FLUSH state.
- Simultaneous events:
  - exc/interrupt beats ERET and MTC0.
  - An MTC0 to Status that clears IE in the same cycle as a pending interrupt does not prevent it; int_req uses pre-write state.
- Reset mid-flush: returns to RUN with outputs deasserted; no redirect is issued.
- Arithmetic: pc_M-4 is mod 2^32; Count wraps 32'hFFFF_FFFF -> 0.

Decomposition:
- Shared package: CP0 register numbers, ExcCode constants (matching the check stage), Status/Cause bit positions, EXC_VECTOR default, FSM state encoding.
- Sub-module: cp0_timer (Count/Compare/tick/TI), split out as the one natural submodule.

Test Plan:
- Sys in slot: pc_M=32'h8000_0010, exc=1, exc_code=08, in_ds_M=1, EXL=0 -> EPC=32'h8000_000C, BD=1, ExcCode=08, EXL=1; next cycle flush=1, redirect_pc=32'hBFC0_0380, then deasserted.
- AdEL on load: pc_M=32'h8000_0020, sl_addr_M=32'h1000_0002, code 04 -> BadVAddr=32'h1000_0002. Misaligned pc_M=32'h8000_0022 -> BadVAddr=32'h8000_0022.
- Nested: second exception (code 0c) while EXL=1 -> EPC unchanged, ExcCode=0c, redirect to vector.
- ERET: EPC=32'h8000_0100, EXL=1, eret_M=1 -> EXL=0; next cycle redirect_pc=32'h8000_0100; same-cycle exc=1 instead -> vector redirect, EXL stays 1.
- Interrupt: Status=32'h0000_0401 (IM2, IE), hw_int[0]=1, valid instruction -> ExcCode=00, flush. Same stimulus with stall_M=1 -> no commit until stall_M=0.
- Timer: MTC0 Compare=5, Count=0 -> TI=1 after 10 cycles; MTC0 Compare clears TI. Count=32'hFFFF_FFFF wraps to 0.
